// File: rtl/rr_mux_pkg.sv
// Shared constants and helpers for the round-robin channel multiplexer family.
package rr_mux_pkg;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   // Width of a channel index; a 1-channel select still needs one bit.
   function automatic int sel_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_mux_n_if.sv
// Producer-side and consumer-side handshake bundle of rr_mux_n.
// The mux holds the slave view. The environment holds the master view.
interface rr_mux_n_if #(
   parameter int N = 4,
   parameter int W = 8
);
   import rr_mux_pkg::*;

   localparam int SEL_W = sel_w(N);

   // A transfer on either side happens on a rising edge where valid && ready.
   logic [N-1:0]     in_valid;
   logic [N*W-1:0]   in_data;
   logic [N-1:0]     in_ready;
   logic             out_valid;
   logic [W-1:0]     out_data;
   logic [SEL_W-1:0] out_sel;
   logic             out_ready;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sel
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sel
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational N-way arbiter: round-robin from i_ptr, or fixed priority with channel 0 highest.
// The pointer register belongs to the caller.
module rr_arbiter
   import rr_mux_pkg::*;
#(
   parameter int N  = 4,
   parameter int RR = ARB_RR
) (
   input  logic [N-1:0]        i_req,
   input  logic [sel_w(N)-1:0] i_ptr,
   output logic [sel_w(N)-1:0] o_grant,
   output logic                o_grant_valid
);

   localparam int SEL_W = sel_w(N);

   int w_dist;
   int w_best;

   // The winner is the requester nearest to i_ptr in scan order (RR) or the lowest index.
   always_comb begin
      o_grant       = '0;
      o_grant_valid = 1'b0;
      w_dist        = 0;
      w_best        = N;
      for (int i = 0; i < N; i++) begin
         if (i_req[i]) begin
            if (RR == ARB_RR)
               w_dist = (i >= int'(i_ptr)) ? i - int'(i_ptr) : i + N - int'(i_ptr);
            else
               w_dist = i;
            if (w_dist < w_best) begin
               w_best        = w_dist;
               o_grant       = SEL_W'(i);
               o_grant_valid = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/rr_mux_n.sv
// Registered N-to-1 stream multiplexer with hardware-chosen select and output backpressure.
// in_ready depends combinationally on out_ready.
module rr_mux_n
   import rr_mux_pkg::*;
#(
   parameter int N  = 4,
   parameter int W  = 8,
   parameter int RR = ARB_RR
) (
   input  logic                clk,
   input  logic                rst,
   rr_mux_n_if.slave           bus,
   output logic [sel_w(N)-1:0] o_dbg_ptr
);

   localparam int SEL_W = sel_w(N);

   logic [SEL_W-1:0] r_ptr;
   logic             r_out_valid;
   logic [W-1:0]     r_out_data;
   logic [SEL_W-1:0] r_out_sel;

   logic [SEL_W-1:0] w_grant;
   logic             w_grant_valid;
   logic             w_space;
   logic             w_load;
   logic [N-1:0]     w_in_ready;
   logic [W-1:0]     w_sel_data;
   logic [SEL_W-1:0] w_ptr_next;

   rr_arbiter #(
      .N  (N),
      .RR (RR)
   ) u_arb (
      .i_req         (bus.in_valid),
      .i_ptr         (r_ptr),
      .o_grant       (w_grant),
      .o_grant_valid (w_grant_valid)
   );

   // The output slot is free when it is empty or is being drained on this edge.
   assign w_space = !r_out_valid || bus.out_ready;
   assign w_load  = w_space && w_grant_valid && !rst;

   always_comb begin
      w_in_ready = '0;
      w_sel_data = '0;
      for (int i = 0; i < N; i++) begin
         if (w_grant == SEL_W'(i)) begin
            w_in_ready[i] = w_load;
            w_sel_data    = bus.in_data[i*W +: W];
         end
      end
   end

   assign w_ptr_next = (RR != ARB_RR || w_grant == SEL_W'(N - 1)) ? '0 : w_grant + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sel   <= '0;
      end else if (w_load) begin
         r_ptr       <= w_ptr_next;
         r_out_valid <= 1'b1;
         r_out_data  <= w_sel_data;
         r_out_sel   <= w_grant;
      end else if (r_out_valid && bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_sel   = r_out_sel;
   assign o_dbg_ptr     = r_ptr;

endmodule

// File: tb/tb_rr_mux_n.sv
// Bench for rr_mux_n: a round-robin and a fixed-priority instance share one stimulus stream.
// Both are checked every cycle against a behavioural model and an output scoreboard.
module tb_rr_mux_n;
   import rr_mux_pkg::*;

   localparam int N     = 4;
   localparam int W     = 8;
   localparam int SEL_W = sel_w(N);

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]   in_valid  = '0;
   logic [N*W-1:0] in_data   = '0;
   logic           out_ready = 1'b0;
   logic [SEL_W-1:0] dbg_ptr_rr;
   logic [SEL_W-1:0] dbg_ptr_fx;

   rr_mux_n_if #(.N(N), .W(W)) bus_rr ();
   rr_mux_n_if #(.N(N), .W(W)) bus_fx ();

   assign bus_rr.in_valid  = in_valid;
   assign bus_rr.in_data   = in_data;
   assign bus_rr.out_ready = out_ready;
   assign bus_fx.in_valid  = in_valid;
   assign bus_fx.in_data   = in_data;
   assign bus_fx.out_ready = out_ready;

   rr_mux_n #(.N(N), .W(W), .RR(ARB_RR)) u_dut_rr (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus_rr),
      .o_dbg_ptr (dbg_ptr_rr)
   );

   rr_mux_n #(.N(N), .W(W), .RR(ARB_FIXED)) u_dut_fx (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus_fx),
      .o_dbg_ptr (dbg_ptr_fx)
   );

   // ---------------- scoreboard / model state ----------------
   int tests_run    = 0;
   int tests_failed = 0;
   logic [SEL_W+W-1:0] exp_q[$];

   // Index 0 models the fixed-priority instance, index 1 the round-robin instance.
   logic         m_valid[2];
   logic [W-1:0] m_data[2];
   int           m_sel[2];
   int           m_ptr[2];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Winner = first requesting channel when scanning from ptr around the ring (or from 0).
   function automatic int model_grant(input logic [N-1:0] v, input int ptr, input int mode);
      for (int k = 0; k < N; k++) begin
         int c;
         c = (mode == ARB_RR) ? (ptr + k) % N : k;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   // ---------------- driver: one clock cycle with current inputs ----------------
   task automatic step();
      int           g;
      int           g_rr;
      logic         ld;
      logic         ld_rr;
      logic [N-1:0] exp_rdy;
      logic [N-1:0] obs_rdy;
      logic         nx_valid[2];
      logic [W-1:0] nx_data[2];
      int           nx_sel[2];
      int           nx_ptr[2];
      g_rr  = -1;
      ld_rr = 1'b0;
      #1;
      for (int m = 0; m < 2; m++) begin
         g  = model_grant(in_valid, m_ptr[m], m);
         ld = !rst && (!m_valid[m] || out_ready) && (g >= 0);
         exp_rdy = '0;
         if (ld) exp_rdy[g] = 1'b1;
         obs_rdy = (m == ARB_RR) ? bus_rr.in_ready : bus_fx.in_ready;
         check_eq((m == ARB_RR) ? "rr_in_ready" : "fx_in_ready", 32'(obs_rdy), 32'(exp_rdy));
         nx_valid[m] = m_valid[m];
         nx_data[m]  = m_data[m];
         nx_sel[m]   = m_sel[m];
         nx_ptr[m]   = m_ptr[m];
         if (rst) begin
            nx_valid[m] = 1'b0;
            nx_data[m]  = '0;
            nx_sel[m]   = 0;
            nx_ptr[m]   = 0;
         end else if (ld) begin
            nx_valid[m] = 1'b1;
            nx_data[m]  = in_data[g*W +: W];
            nx_sel[m]   = g;
            nx_ptr[m]   = (m == ARB_RR) ? (g + 1) % N : 0;
         end else if (m_valid[m] && out_ready) begin
            nx_valid[m] = 1'b0;
         end
         if (m == ARB_RR) begin
            g_rr  = g;
            ld_rr = ld;
         end
      end
      // Every word presented by the round-robin instance must leave exactly once, in order.
      if (!rst && m_valid[ARB_RR] && out_ready) begin
         check_eq("sb_pending", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0)
            check_eq("sb_word", 32'({bus_rr.out_sel, bus_rr.out_data}), 32'(exp_q.pop_front()));
      end
      if (rst) exp_q.delete();
      else if (ld_rr) exp_q.push_back({SEL_W'(g_rr), in_data[g_rr*W +: W]});
      @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
         m_valid[m] = nx_valid[m];
         m_data[m]  = nx_data[m];
         m_sel[m]   = nx_sel[m];
         m_ptr[m]   = nx_ptr[m];
      end
      check_eq("rr_out_valid", 32'(bus_rr.out_valid), 32'(m_valid[1]));
      check_eq("rr_out_data",  32'(bus_rr.out_data),  32'(m_data[1]));
      check_eq("rr_out_sel",   32'(bus_rr.out_sel),   32'(m_sel[1]));
      check_eq("rr_ptr",       32'(dbg_ptr_rr),       32'(m_ptr[1]));
      check_eq("fx_out_valid", 32'(bus_fx.out_valid), 32'(m_valid[0]));
      check_eq("fx_out_data",  32'(bus_fx.out_data),  32'(m_data[0]));
      check_eq("fx_out_sel",   32'(bus_fx.out_sel),   32'(m_sel[0]));
      check_eq("fx_ptr",       32'(dbg_ptr_fx),       32'(m_ptr[0]));
   endtask

   task automatic set_ramp_data();
      for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'h10 + W'(i);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [W-1:0]     held_data;
      logic [SEL_W-1:0] held_sel;
      int               sel_hist[$];
      logic [N-1:0]     seen;
      for (int m = 0; m < 2; m++) begin
         m_valid[m] = 1'b0;
         m_data[m]  = '0;
         m_sel[m]   = 0;
         m_ptr[m]   = 0;
      end

      // Reset held two cycles with every channel requesting.
      rst       = 1'b1;
      in_valid  = '1;
      in_data   = $urandom;
      out_ready = 1'b1;
      repeat (2) begin
         step();
         check_eq("rst_in_ready", 32'(bus_rr.in_ready), 32'd0);
         check_eq("rst_out_valid", 32'(bus_rr.out_valid), 32'd0);
      end
      rst = 1'b0;

      // Round-robin sweep: no bubbles, sel 0,1,2,3,0,...
      set_ramp_data();
      for (int k = 0; k < 8; k++) begin
         step();
         check_eq("rr_seq_sel", 32'(bus_rr.out_sel), 32'(k % N));
         check_eq("rr_seq_data", 32'(bus_rr.out_data), 32'(8'h10 + k % N));
         check_eq("rr_seq_valid", 32'(bus_rr.out_valid), 32'd1);
      end

      // Backpressure: the held word must not move and nothing is accepted.
      out_ready = 1'b0;
      held_data = bus_rr.out_data;
      held_sel  = bus_rr.out_sel;
      repeat (5) begin
         #1;
         check_eq("bp_in_ready", 32'(bus_rr.in_ready), 32'd0);
         step();
         check_eq("bp_data", 32'(bus_rr.out_data), 32'(held_data));
         check_eq("bp_sel", 32'(bus_rr.out_sel), 32'(held_sel));
      end
      out_ready = 1'b1;
      step();
      check_eq("bp_release_sel", 32'(bus_rr.out_sel), 32'd0);
      check_eq("bp_release_data", 32'(bus_rr.out_data), 32'h10);

      // Single requester on channel 2.
      in_valid = 4'b0100;
      in_data  = $urandom;
      in_data[2*W +: W] = 8'hA5;
      #1;
      check_eq("single_in_ready", 32'(bus_rr.in_ready), 32'b0100);
      step();
      check_eq("single_data", 32'(bus_rr.out_data), 32'hA5);
      check_eq("single_sel", 32'(bus_rr.out_sel), 32'd2);

      // Fixed priority: channel 1 keeps beating channel 3 until it drops.
      in_valid = 4'b1010;
      set_ramp_data();
      repeat (4) begin
         step();
         check_eq("fx_prio_sel", 32'(bus_fx.out_sel), 32'd1);
      end
      in_valid = 4'b1000;
      step();
      check_eq("fx_prio_release", 32'(bus_fx.out_sel), 32'd3);

      // Reset mid-stream with ptr at 2.
      rst = 1'b1;
      step();
      rst      = 1'b0;
      in_valid = '1;
      repeat (2) step();
      check_eq("mid_ptr_before", 32'(dbg_ptr_rr), 32'd2);
      rst = 1'b1;
      step();
      check_eq("mid_rst_valid", 32'(bus_rr.out_valid), 32'd0);
      check_eq("mid_rst_ptr", 32'(dbg_ptr_rr), 32'd0);
      rst = 1'b0;
      step();
      check_eq("mid_first_grant", 32'(bus_rr.out_sel), 32'd0);

      // Randomised traffic, occasional resets.
      for (int c = 0; c < 800; c++) begin
         in_valid  = N'($urandom_range(0, (1 << N) - 1));
         in_data   = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         rst       = ($urandom_range(0, 99) == 0);
         step();
      end
      rst = 1'b0;

      // Fairness: any N consecutive loads with everyone requesting cover every channel.
      in_valid  = '1;
      out_ready = 1'b1;
      for (int k = 0; k < 3 * N; k++) begin
         in_data = $urandom;
         step();
         sel_hist.push_back(int'(bus_rr.out_sel));
      end
      for (int s = 1; s + N <= sel_hist.size(); s++) begin
         seen = '0;
         for (int j = 0; j < N; j++) seen[sel_hist[s+j]] = 1'b1;
         check_eq("rr_fairness", 32'(seen), 32'((1 << N) - 1));
      end

      // ---------------- report ----------------
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
